// File: rtl/count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// count_monitor_pkg
// Shared types for the count_monitor observer:
//   evt_type_t  - event classification written into the event FIFO
//   cm_state_t  - classifier FSM state (PRIME until the first sample, then TRACK)
//   evt_rec_t   - one FIFO record {type, value}
// CNT_W is the observed counter width the record is built for; the top-level
// WIDTH parameter defaults to it and must stay equal to it.
// -----------------------------------------------------------------------------
package count_monitor_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_WRAP  = 2'b01,
        EVT_JUMP  = 2'b10,
        EVT_STALL = 2'b11
    } evt_type_t;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_TRACK = 1'b1
    } cm_state_t;

    typedef struct packed {
        evt_type_t              etype;
        logic [CNT_W-1:0]       value;
    } evt_rec_t;

endpackage

// File: rtl/count_monitor_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// head_data whenever empty is low; pop consumes it.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   push, push_data   write request; accepted when not full, or when full
//                     and a pop happens in the same cycle
//   pop               consume head; ignored when empty
//   head_data         current head entry (valid while !empty)
//   full, empty       occupancy flags
//   level             current number of stored entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module evt_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the slot the push needs, so a full FIFO still accepts
    // a push in a cycle where it is also being read.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; a write during reset is harmless because
    // the pointers and level are cleared on the same edge.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
// Observes a free-running counter and classifies each strobed transition:
// +1 (silent), wrap from all-ones to zero (WRAP), repeated value (STALL once
// STALL_LIM identical samples are seen), anything else (JUMP). Events are
// registered for one cycle, then pushed into an FWFT event FIFO drained over
// a valid/ready handshake. A saturating wrap tally and a sticky overflow
// flag (event dropped on a full FIFO) are also kept.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   count_in          observed counter value, sampled when count_valid=1
//   count_valid       sample strobe
//   evt_valid         FIFO head holds an event
//   evt_ready         consumer takes the head this cycle
//   evt_type          01 WRAP, 10 JUMP, 11 STALL (00 when no event)
//   evt_value         count_in at the sample that raised the event
//   wrap_count        saturating number of WRAP events detected
//   overflow          sticky: an event was dropped because the FIFO was full
//   fifo_level        current FIFO occupancy
// -----------------------------------------------------------------------------
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = CNT_W,
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned STALL_LIM  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_type,
    output logic [WIDTH-1:0]  evt_value,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifo_level
);

    // Stall run counts repeats (not samples) and saturates at STALL_LIM, so
    // it needs enough bits to hold STALL_LIM itself.
    localparam int unsigned RUN_W = $clog2(STALL_LIM + 1);
    localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(STALL_LIM);
    localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'(STALL_LIM - 2);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    cm_state_t         state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              pend_valid_q, pend_valid_d;
    evt_rec_t          pend_rec_q, pend_rec_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              overflow_q, overflow_d;

    logic [WIDTH-1:0]  prev_inc;
    logic [$bits(evt_rec_t)-1:0] head_bits;
    evt_rec_t          head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              evt_pop;

    assign prev_inc = prev_q + WIDTH'(1);

    // ---------------------------------------------------------------------
    // Classifier: decides the event for this sample and latches it into the
    // pending register; the push happens one edge later.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        pend_valid_d = 1'b0;
        pend_rec_d   = '{etype: EVT_NONE, value: count_in};

        if (count_valid) begin
            prev_d = count_in;
            if (state_q == ST_PRIME) begin
                state_d = ST_TRACK;
            end else if (prev_q == ALL_ONES && count_in == '0) begin
                // Checked before the +1 test: all-ones +1 also equals zero.
                pend_valid_d     = 1'b1;
                pend_rec_d.etype = EVT_WRAP;
                run_d            = '0;
            end else if (count_in == prev_inc) begin
                run_d = '0;
            end else if (count_in == prev_q) begin
                if (run_q != RUN_SAT) begin
                    run_d = run_q + RUN_W'(1);
                end
                // Fires only on the step to STALL_LIM-1 repeats; the run
                // keeps climbing past it, so it cannot fire again.
                if (run_q == RUN_FIRE) begin
                    pend_valid_d     = 1'b1;
                    pend_rec_d.etype = EVT_STALL;
                end
            end else begin
                pend_valid_d     = 1'b1;
                pend_rec_d.etype = EVT_JUMP;
                run_d            = '0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Push-side bookkeeping: tally and overflow move with the push edge.
    // ---------------------------------------------------------------------
    assign evt_pop = evt_valid && evt_ready;

    always_comb begin
        wrap_d     = wrap_q;
        overflow_d = overflow_q;
        if (pend_valid_q && pend_rec_q.etype == EVT_WRAP && wrap_q != '1) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end
        if (pend_valid_q && fifo_full && !evt_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PRIME;
            prev_q       <= '0;
            run_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_rec_q   <= '{etype: EVT_NONE, value: '0};
            wrap_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            pend_valid_q <= pend_valid_d;
            pend_rec_q   <= pend_rec_d;
            wrap_q       <= wrap_d;
            overflow_q   <= overflow_d;
        end
    end

    evt_fifo #(
        .DATA_W ($bits(evt_rec_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pend_valid_q),
        .push_data (pend_rec_q),
        .pop       (evt_pop),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign head_rec = head_bits;

    // Head is gated so type/value read as zero whenever the FIFO is empty,
    // which also gives clean zeros straight after reset.
    assign evt_valid  = !fifo_empty;
    assign evt_type   = fifo_empty ? 2'b00 : head_rec.etype;
    assign evt_value  = fifo_empty ? '0    : head_rec.value;
    assign wrap_count = wrap_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_monitor
// Directed stimulus for count_monitor with default parameters
// (WIDTH=4, WRAP_W=8, STALL_LIM=8, FIFO_DEPTH=4). Inputs change 1 time unit
// after each rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_count_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [3:0] evt_value;
    logic [7:0] wrap_count;
    logic       overflow;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    count_monitor #(
        .WIDTH      (4),
        .WRAP_W     (8),
        .STALL_LIM  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_type    (evt_type),
        .evt_value   (evt_value),
        .wrap_count  (wrap_count),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 unit past it.
    task automatic cyc(input logic v, input logic [3:0] val, input logic rdy);
        count_valid = v;
        count_in    = val;
        evt_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] val);
        cyc(1'b1, val, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0);
    endtask

    // Check the head record, then consume it.
    task automatic drain_expect(input string tag, input logic [1:0] t, input logic [3:0] v);
        check({tag, ".valid"}, 32'(evt_valid), 32'd1);
        check({tag, ".type"},  32'(evt_type),  32'(t));
        check({tag, ".value"}, 32'(evt_value), 32'(v));
        cyc(1'b0, 4'd0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".evt_valid"},  32'(evt_valid),  32'd0);
        check({tag, ".evt_type"},   32'(evt_type),   32'd0);
        check({tag, ".evt_value"},  32'(evt_value),  32'd0);
        check({tag, ".wrap_count"}, 32'(wrap_count), 32'd0);
        check({tag, ".overflow"},   32'(overflow),   32'd0);
        check({tag, ".fifo_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        count_in    = 4'd0;
        count_valid = 1'b0;
        evt_ready   = 1'b0;
        #1;
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        check_reset_outputs("rst");
        reset = 1'b0;

        // ---- counting 0..15,0,1: one WRAP with value 0 ----
        for (int i = 0; i < 16; i++) sample(4'(i));
        sample(4'd0);                                   // WRAP sampled here
        check("wrap.lat_pending", 32'(evt_valid), 32'd0);
        sample(4'd1);                                   // pushed on this edge
        check("wrap.lat_valid", 32'(evt_valid), 32'd1);
        check("wrap.type", 32'(evt_type), 32'd1);
        check("wrap.value", 32'(evt_value), 32'd0);
        check("wrap.count", 32'(wrap_count), 32'd1);
        idle(1);
        check("wrap.level", 32'(fifo_level), 32'd1);
        cyc(1'b0, 4'd0, 1'b1);
        check("wrap.level_after_pop", 32'(fifo_level), 32'd0);
        check("wrap.valid_after_pop", 32'(evt_valid), 32'd0);

        // ---- counter reset mid-count: 2..9,0,1 -> one JUMP value 0 ----
        for (int i = 2; i <= 9; i++) sample(4'(i));
        sample(4'd0);
        sample(4'd1);
        idle(2);
        check("jump.level", 32'(fifo_level), 32'd1);
        check("jump.type", 32'(evt_type), 32'd2);
        check("jump.value", 32'(evt_value), 32'd0);
        check("jump.wrap_count", 32'(wrap_count), 32'd1);
        cyc(1'b0, 4'd0, 1'b1);

        // ---- stall: twelve 5s -> one STALL; seven 6s -> none; eighth 6 -> STALL ----
        for (int i = 2; i <= 4; i++) sample(4'(i));
        for (int i = 0; i < 12; i++) sample(4'd5);
        for (int i = 0; i < 7; i++) sample(4'd6);
        idle(2);
        check("stall.level_one", 32'(fifo_level), 32'd1);
        sample(4'd6);
        idle(2);
        check("stall.level_two", 32'(fifo_level), 32'd2);
        drain_expect("stall5", 2'b11, 4'd5);
        drain_expect("stall6", 2'b11, 4'd6);
        check("stall.level_empty", 32'(fifo_level), 32'd0);

        // ---- full FIFO, WRAP pushed in the same cycle as a pop ----
        sample(4'd10);
        sample(4'd3);
        sample(4'd12);
        sample(4'd14);
        sample(4'd15);
        sample(4'd0);                                   // WRAP pending, FIFO now full
        check("fullpop.level_full", 32'(fifo_level), 32'd4);
        cyc(1'b0, 4'd0, 1'b1);                          // push and pop together
        check("fullpop.level", 32'(fifo_level), 32'd4);
        check("fullpop.overflow", 32'(overflow), 32'd0);
        check("fullpop.wrap_count", 32'(wrap_count), 32'd2);
        drain_expect("fullpop0", 2'b10, 4'd3);
        drain_expect("fullpop1", 2'b10, 4'd12);
        drain_expect("fullpop2", 2'b10, 4'd14);
        drain_expect("fullpop3", 2'b01, 4'd0);
        check("fullpop.level_empty", 32'(fifo_level), 32'd0);

        // ---- five JUMPs with no consumer: overflow ----
        sample(4'd10);
        sample(4'd3);
        sample(4'd12);
        sample(4'd1);
        sample(4'd9);
        idle(2);
        check("ovf.level", 32'(fifo_level), 32'd4);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.wrap_count", 32'(wrap_count), 32'd2);
        drain_expect("ovf0", 2'b10, 4'd10);
        drain_expect("ovf1", 2'b10, 4'd3);
        drain_expect("ovf2", 2'b10, 4'd12);
        drain_expect("ovf3", 2'b10, 4'd1);
        check("ovf.level_empty", 32'(fifo_level), 32'd0);
        check("ovf.sticky", 32'(overflow), 32'd1);

        // ---- reset with 3 events queued and one pending ----
        sample(4'd4);
        sample(4'd11);
        sample(4'd2);
        sample(4'd7);                                   // JUMP pending at reset
        check("rst2.level_before", 32'(fifo_level), 32'd3);
        reset = 1'b1;
        cyc(1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        check_reset_outputs("rst2");
        idle(2);
        check("rst2.pending_dropped", 32'(fifo_level), 32'd0);
        sample(4'd13);                                  // primes only
        idle(2);
        check("rst2.prime_level", 32'(fifo_level), 32'd0);
        sample(4'd14);
        sample(4'd3);
        idle(2);
        check("rst2.post_level", 32'(fifo_level), 32'd1);
        check("rst2.post_type", 32'(evt_type), 32'd2);
        check("rst2.post_value", 32'(evt_value), 32'd3);
        check("rst2.post_wrap", 32'(wrap_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
